cnt_down: RTL and testbench

- Synchronous presettable binary down counter: the count-down counterpart of the team's 4-bit up counter (cnt).
- Uses the same control set: CP, MR, CET, CEP, active-low PE, P, Q, TC.
- Adds one-shot and auto-reload modes so it can serve as a programmable timer/divider.
- TC is a borrow lookahead for cascading stages, in the same way the up counter's TC is a carry lookahead.

---
 rtl/cnt_down.sv | 104 ++++++++++
 tb/tb_cnt_down.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnt_down.sv
// Synchronous presettable down counter with one-shot / auto-reload modes and a
// borrow-lookahead TC. Optional prescaler enabled by defining CNT_DOWN_PRESCALE_EN.
module cnt_down #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 4
) (
  input  logic             CP,
  input  logic             MR,
  input  logic             CET,
  input  logic             CEP,
  input  logic             PE,
  input  logic             RL,
  input  logic [WIDTH-1:0] P,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             BUSY,
  output logic             DONE
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_rl;
  logic             w_en;
  logic             w_step;
  logic             w_zero;
  logic             w_ps_wrap;

`ifdef CNT_DOWN_PRESCALE_EN
  localparam bit PS_ON = 1'b1;
`else
  localparam bit PS_ON = 1'b0;
`endif

  if (PS_ON && (PRESCALE < 2 || PRESCALE > 256)) begin : g_bad_prescale
    $error("cnt_down: PRESCALE must be in 2..256");
  end

  assign w_zero = (r_q == '0);
  assign w_en   = CET & CEP & (r_state == S_RUN) & PE & ~MR;

`ifdef CNT_DOWN_PRESCALE_EN
  localparam int             PSW    = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PSW-1:0] PS_MAX = PSW'(PRESCALE - 1);

  logic [PSW-1:0] r_ps;

  assign w_ps_wrap = (r_ps == PS_MAX);

  always_ff @(posedge CP) begin
    if (MR || !PE)
      r_ps <= '0;
    else if (w_en)
      r_ps <= w_ps_wrap ? '0 : r_ps + PSW'(1);
  end
`else
  assign w_ps_wrap = 1'b1;
`endif

  // A count step is an enabled edge that also completes the prescale period.
  assign w_step = w_en & w_ps_wrap;

  always_ff @(posedge CP) begin
    if (MR) begin
      r_q  <= '0;
      r_rl <= '0;
    end else if (!PE) begin
      r_q  <= P;
      r_rl <= P;
    end else if (w_step) begin
      if (!w_zero)
        r_q <= r_q - WIDTH'(1);
      else if (RL)
        r_q <= r_rl;
    end
  end

  always_ff @(posedge CP) begin
    if (MR)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!PE)
      w_state_nxt = S_RUN;
    else if (w_step && w_zero && !RL)
      w_state_nxt = S_DONE;
  end

  always_comb begin
    BUSY = (r_state == S_RUN);
    DONE = (r_state == S_DONE);
  end

  // TC ignores CEP, state and PE so stages can chain through CET.
  assign Q  = r_q;
  assign TC = CET & w_zero & w_ps_wrap;

endmodule

// File: tb/tb_cnt_down.sv
// Bench for cnt_down: directed scenarios plus randomized traffic against a
// behavioural model of the counter.
module tb_cnt_down;

`ifdef CNT_DOWN_PRESCALE_EN
  localparam int TB_PS = 4;
`else
  localparam int TB_PS = 1;
`endif

  logic       CP;
  logic       MR, CET, CEP, PE, RL;
  logic [3:0] P;
  logic [3:0] Q;
  logic       TC, BUSY, DONE;

  int n_tests = 0;
  int n_fail  = 0;

  // behavioural model state
  int m_q, m_r, m_ps;
  bit m_run, m_done;

  cnt_down u_dut (
    .CP(CP), .MR(MR), .CET(CET), .CEP(CEP), .PE(PE), .RL(RL), .P(P),
    .Q(Q), .TC(TC), .BUSY(BUSY), .DONE(DONE)
  );

`ifndef CNT_DOWN_PRESCALE_EN
  logic       c_mr, c_cep, c_rl, c_pe_lo, c_pe_hi;
  logic [3:0] c_p_lo, c_p_hi, c_q_lo, c_q_hi;
  logic       c_tc_lo, c_tc_hi, c_busy_lo, c_busy_hi, c_done_lo, c_done_hi;
  logic       c_cet_lo;
  assign c_cet_lo = 1'b1;

  cnt_down u_lo (
    .CP(CP), .MR(c_mr), .CET(c_cet_lo), .CEP(c_cep), .PE(c_pe_lo), .RL(c_rl), .P(c_p_lo),
    .Q(c_q_lo), .TC(c_tc_lo), .BUSY(c_busy_lo), .DONE(c_done_lo)
  );
  cnt_down u_hi (
    .CP(CP), .MR(c_mr), .CET(c_tc_lo), .CEP(c_cep), .PE(c_pe_hi), .RL(c_rl), .P(c_p_hi),
    .Q(c_q_hi), .TC(c_tc_hi), .BUSY(c_busy_hi), .DONE(c_done_hi)
  );
`endif

  initial CP = 1'b0;
  always #5 CP = ~CP;

  // Advance the model by one rising edge using the inputs now applied.
  task automatic model_edge();
    if (MR) begin
      m_q = 0; m_r = 0; m_ps = 0; m_run = 0; m_done = 0;
    end else if (!PE) begin
      m_q = int'(P); m_r = int'(P); m_ps = 0; m_run = 1; m_done = 0;
    end else if (CET && CEP && m_run) begin
      if (m_ps < TB_PS - 1) begin
        m_ps = m_ps + 1;
      end else begin
        m_ps = 0;
        if (m_q > 0)   m_q = m_q - 1;
        else if (RL)   m_q = m_r;
        else begin m_run = 0; m_done = 1; end
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge CP);
    #1;
  endtask

  task automatic load(input int val, input logic rl);
    PE = 1'b0; P = 4'(val); RL = rl; CET = 1'b1; CEP = 1'b1;
    tick();
    PE = 1'b1;
  endtask

  task automatic test_reset();
    MR = 1'b1; PE = 1'b0; CET = 1'b1; CEP = 1'b1; RL = 1'b0; P = 4'hA;
    tick(); tick();
    MR = 1'b1; PE = 1'b1;
    #1;
    n_tests++; if (Q !== 4'd0)  begin n_fail++; $display("FAIL reset_q: got %0d want 0", Q); end
    n_tests++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", BUSY); end
    n_tests++; if (DONE !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", DONE); end
    n_tests++; if (TC !== 1'b1)   begin n_fail++; $display("FAIL reset_tc_cet1: got %b want 1", TC); end
    CET = 1'b0;
    #1;
    n_tests++; if (TC !== 1'b0)   begin n_fail++; $display("FAIL reset_tc_cet0: got %b want 0", TC); end
    tick();
    MR = 1'b0; CET = 1'b1;
  endtask

`ifndef CNT_DOWN_PRESCALE_EN
  task automatic test_oneshot();
    load(5, 1'b0);
    for (int i = 0; i < 6; i++) begin
      n_tests++;
      if (Q !== 4'(5 - i) || BUSY !== 1'b1 || TC !== (i == 5)) begin
        n_fail++;
        $display("FAIL oneshot_step%0d: Q=%0d BUSY=%b TC=%b want Q=%0d BUSY=1 TC=%b", i, Q, BUSY, TC, 5 - i, i == 5);
      end
      if (i < 5) tick();
    end
    tick();
    n_tests++;
    if (DONE !== 1'b1 || BUSY !== 1'b0 || Q !== 4'd0) begin
      n_fail++; $display("FAIL oneshot_done: DONE=%b BUSY=%b Q=%0d want 1 0 0", DONE, BUSY, Q);
    end
    tick(); tick();
    n_tests++;
    if (Q !== 4'd0 || DONE !== 1'b1 || TC !== 1'b1) begin
      n_fail++; $display("FAIL oneshot_hold: Q=%0d DONE=%b TC=%b want 0 1 1", Q, DONE, TC);
    end
  endtask

  task automatic test_autoreload();
    load(3, 1'b1);
    for (int i = 0; i < 10; i++) begin
      n_tests++;
      if (Q !== 4'(3 - (i % 4)) || BUSY !== 1'b1 || DONE !== 1'b0) begin
        n_fail++;
        $display("FAIL reload_step%0d: Q=%0d BUSY=%b DONE=%b want Q=%0d 1 0", i, Q, BUSY, DONE, 3 - (i % 4));
      end
      tick();
    end
    CEP = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (Q !== 4'd1) begin n_fail++; $display("FAIL cep_freeze%0d: Q=%0d want 1", i, Q); end
    end
    CEP = 1'b1;
    tick();
    CET = 1'b0;
    #1;
    n_tests++; if (TC !== 1'b0) begin n_fail++; $display("FAIL cet_gate_tc: TC=%b want 0", TC); end
    tick(); tick();
    n_tests++; if (Q !== 4'd0) begin n_fail++; $display("FAIL cet_freeze: Q=%0d want 0", Q); end
    CET = 1'b1;
    #1;
    n_tests++; if (TC !== 1'b1) begin n_fail++; $display("FAIL cet_tc_back: TC=%b want 1", TC); end
  endtask

  task automatic test_priority();
    load(5, 1'b0);
    tick(); tick(); tick();
    n_tests++; if (Q !== 4'd2) begin n_fail++; $display("FAIL prio_pre: Q=%0d want 2", Q); end
    PE = 1'b0; P = 4'd9; CET = 1'b1; CEP = 1'b1;
    tick();
    PE = 1'b1;
    n_tests++; if (Q !== 4'd9) begin n_fail++; $display("FAIL load_beats_count: Q=%0d want 9", Q); end
    tick(); tick(); tick();
    n_tests++; if (Q !== 4'd6) begin n_fail++; $display("FAIL prio_at6: Q=%0d want 6", Q); end
    MR = 1'b1; PE = 1'b0; P = 4'd12;
    tick();
    MR = 1'b0; PE = 1'b1;
    n_tests++;
    if (Q !== 4'd0 || BUSY !== 1'b0 || DONE !== 1'b0) begin
      n_fail++; $display("FAIL mr_beats_load: Q=%0d BUSY=%b DONE=%b want 0 0 0", Q, BUSY, DONE);
    end
    tick(); tick(); tick();
    n_tests++;
    if (Q !== 4'd0 || BUSY !== 1'b0) begin
      n_fail++; $display("FAIL idle_ignores_en: Q=%0d BUSY=%b want 0 0", Q, BUSY);
    end
  endtask

  task automatic test_restart();
    load(1, 1'b0);
    tick(); tick();
    n_tests++; if (DONE !== 1'b1) begin n_fail++; $display("FAIL restart_pre_done: DONE=%b want 1", DONE); end
    load(7, 1'b0);
    n_tests++;
    if (Q !== 4'd7 || BUSY !== 1'b1 || DONE !== 1'b0) begin
      n_fail++; $display("FAIL restart_load: Q=%0d BUSY=%b DONE=%b want 7 1 0", Q, BUSY, DONE);
    end
    tick();
    n_tests++; if (Q !== 4'd6) begin n_fail++; $display("FAIL restart_count: Q=%0d want 6", Q); end
    load(0, 1'b0);
    n_tests++;
    if (Q !== 4'd0 || BUSY !== 1'b1) begin
      n_fail++; $display("FAIL zero_load: Q=%0d BUSY=%b want 0 1", Q, BUSY);
    end
    tick();
    n_tests++;
    if (DONE !== 1'b1 || BUSY !== 1'b0) begin
      n_fail++; $display("FAIL zero_done: DONE=%b BUSY=%b want 1 0", DONE, BUSY);
    end
  endtask

  task automatic test_cascade();
    c_mr = 1'b1; c_pe_lo = 1'b1; c_pe_hi = 1'b1; c_cep = 1'b0; c_rl = 1'b1;
    c_p_lo = 4'h0; c_p_hi = 4'h0;
    tick();
    // Low stage must hold F as its reload value, so load F and count it down to 1.
    c_mr = 1'b0; c_pe_lo = 1'b0; c_p_lo = 4'hF; c_pe_hi = 1'b0; c_p_hi = 4'h2;
    tick();
    c_pe_lo = 1'b1; c_pe_hi = 1'b1; c_cep = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    n_tests++;
    if ({c_q_hi, c_q_lo} !== 8'h21) begin
      n_fail++; $display("FAIL cascade_start: got %h want 21", {c_q_hi, c_q_lo});
    end
    for (int v = 8'h20; v >= 0; v--) begin
      tick();
      n_tests++;
      if ({c_q_hi, c_q_lo} !== 8'(v)) begin
        n_fail++; $display("FAIL cascade_val: got %h want %h", {c_q_hi, c_q_lo}, 8'(v));
      end
    end
    c_cep = 1'b0;
  endtask
`else
  task automatic test_prescale();
    load(2, 1'b0);
    for (int i = 0; i < 12; i++) begin
      n_tests++;
      if (Q !== 4'(2 - i / 4) || TC !== ((i / 4 == 2) && (i % 4 == 3)) || DONE !== 1'b0) begin
        n_fail++;
        $display("FAIL prescale_step%0d: Q=%0d TC=%b DONE=%b want Q=%0d TC=%b DONE=0",
                 i, Q, TC, DONE, 2 - i / 4, (i / 4 == 2) && (i % 4 == 3));
      end
      tick();
    end
    n_tests++;
    if (DONE !== 1'b1 || Q !== 4'd0) begin
      n_fail++; $display("FAIL prescale_done: DONE=%b Q=%0d want 1 0", DONE, Q);
    end
  endtask
`endif

  task automatic test_random();
    bit exp_tc;
    for (int i = 0; i < 600; i++) begin
      MR  = ($urandom_range(0, 31) == 0);
      PE  = ($urandom_range(0, 11) != 0);
      CET = ($urandom_range(0, 3) != 0);
      CEP = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) RL = 1'($urandom);
      P   = 4'($urandom);
      #1;
      exp_tc = CET && (m_q == 0) && (m_ps == TB_PS - 1);
      n_tests++;
      if (TC !== exp_tc) begin
        n_fail++; $display("FAIL rand_tc cyc%0d: got %b want %b", i, TC, exp_tc);
      end
      tick();
      n_tests++;
      if (Q !== 4'(m_q) || BUSY !== m_run || DONE !== m_done) begin
        n_fail++;
        $display("FAIL rand_state cyc%0d: Q=%0d BUSY=%b DONE=%b want Q=%0d BUSY=%b DONE=%b",
                 i, Q, BUSY, DONE, m_q, m_run, m_done);
      end
    end
  endtask

  initial begin
    MR = 1'b1; CET = 1'b0; CEP = 1'b0; PE = 1'b1; RL = 1'b0; P = 4'd0;
    m_q = 0; m_r = 0; m_ps = 0; m_run = 0; m_done = 0;
`ifndef CNT_DOWN_PRESCALE_EN
    c_mr = 1'b1; c_cep = 1'b0; c_rl = 1'b0; c_pe_lo = 1'b1; c_pe_hi = 1'b1;
    c_p_lo = 4'd0; c_p_hi = 4'd0;
`endif
    #2;
    test_reset();
`ifndef CNT_DOWN_PRESCALE_EN
    test_oneshot();
    test_autoreload();
    test_priority();
    test_restart();
    test_cascade();
`else
    test_prescale();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
